// File: rtl/lcd1602_writer.sv
// lcd1602_writer: HD44780 write sequencer with setup/E-pulse/hold timing and execution wait.
// Define LCD_NIBBLE_MODE_EN for a 4-bit bus (two E pulses per byte on lcd_db[7:4]).
module lcd1602_writer #(
  parameter int T_AS   = 2,
  parameter int T_PW   = 8,
  parameter int T_H    = 2,
  parameter int T_EXEC = 640,
  parameter int T_LONG = 25000,
  parameter int CW     = 16
) (
  input  logic       in_clock,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  input  logic       wr_rs,
  input  logic       clr_ovr,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic       overrun
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] EHIGH = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;

  logic [2:0]    r_state, w_next;
  logic [CW-1:0] r_cnt, w_load;
  logic [7:0]    r_data;
  logic          r_rs, r_ovr, w_more, w_long;

  // clear display and return home need the long execution wait
  assign w_long = !r_rs && r_data <= 8'h03;

  always_comb begin
    w_next = r_state == SETUP ? EHIGH :
             r_state == EHIGH ? HOLD  :
             r_state == HOLD  ? (w_more ? SETUP : WAIT) : IDLE;
    w_load = w_next == SETUP ? CW'(T_AS - 1) :
             w_next == EHIGH ? CW'(T_PW - 1) :
             w_next == HOLD  ? CW'(T_H - 1)  :
             w_next == WAIT  ? (w_long ? CW'(T_LONG - 1) : CW'(T_EXEC - 1)) : '0;
  end

  always_ff @(posedge in_clock or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= 8'h00;
      r_rs    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= (wr_stb && r_state != IDLE) || (r_ovr && !clr_ovr);
      if (r_state == IDLE) begin
        if (wr_stb) begin
          r_data  <= wr_data;
          r_rs    <= wr_rs;
          r_state <= SETUP;
          r_cnt   <= CW'(T_AS - 1);
        end
      end else if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      else begin
        r_state <= w_next;
        r_cnt   <= w_load;
      end
    end

`ifdef LCD_NIBBLE_MODE_EN
  logic r_nib;
  always_ff @(posedge in_clock or negedge rst)
    if (!rst) r_nib <= 1'b0;
    else if (r_state == IDLE && wr_stb) r_nib <= 1'b0;
    else if (r_state == HOLD && r_cnt == '0) r_nib <= 1'b1;
  assign w_more = r_state == HOLD && !r_nib;
  assign lcd_db = {r_nib ? r_data[3:0] : r_data[7:4], 4'h0};
`else
  assign w_more = 1'b0;
  assign lcd_db = r_data;
`endif

  assign lcd_rs  = r_rs;
  assign lcd_rw  = 1'b0;
  assign lcd_e   = r_state == EHIGH;
  assign busy    = r_state != IDLE;
  assign overrun = r_ovr;
endmodule
